// File: rtl/b_to_f_core.sv
// Field-to-frequency converter: freq = map(k * (c + (b*B)>>>25 + (a*((B*B)>>25))>>>25)).
// Define B2F_SATURATE_EN to clamp the result to [0, 2^32-1] instead of wrapping modulo 2^32.
module b_to_f_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] b_field,
  input  logic [31:0] a_coeff,
  input  logic [31:0] b_coeff,
  input  logic [31:0] c_coeff,
  input  logic [7:0]  k_coeff,
  input  logic        start,
  output logic [31:0] freq,
  output logic        ready
);

  localparam int unsigned DW    = 32;
  localparam int unsigned WW    = 72;
  localparam int unsigned SQ_W  = 39;
  localparam int unsigned FRAC  = 25;
`ifdef B2F_SATURATE_EN
  localparam int unsigned P_W   = WW;
`else
  localparam int unsigned P_W   = DW;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    MA   = 3'd2,
    MB   = 3'd3,
    SUM  = 3'd4,
    MK   = 3'd5,
    OUT  = 3'd6
  } state_t;

  state_t state, state_next;

  logic        [DW-1:0]   bf_r;
  logic        [DW-1:0]   a_r, b_r, c_r;
  logic        [7:0]      k_r;
  logic        [SQ_W-1:0] sq_r;
  logic signed [WW-1:0]   t1_r, t2_r, s_r;
  logic        [P_W-1:0]  p_r;

  // Sign/zero-extended operands so every product is exact in WW bits
  logic signed [WW-1:0] a_ext, b_ext, c_ext, bf_ext, sq_ext, k_ext;
  logic signed [WW-1:0] t1_full, t2_full, p_full;
  logic        [63:0]   sq_full;

  assign a_ext   = {{(WW-DW){a_r[DW-1]}}, a_r};
  assign b_ext   = {{(WW-DW){b_r[DW-1]}}, b_r};
  assign c_ext   = {{(WW-DW){c_r[DW-1]}}, c_r};
  assign bf_ext  = {{(WW-DW){1'b0}}, bf_r};
  assign sq_ext  = {{(WW-SQ_W){1'b0}}, sq_r};
  assign k_ext   = {{(WW-8){1'b0}}, k_r};
  assign sq_full = {32'd0, bf_r} * {32'd0, bf_r};
  assign t2_full = (a_ext * sq_ext) >>> FRAC;
  assign t1_full = (b_ext * bf_ext) >>> FRAC;
  assign p_full  = s_r * k_ext;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: one datapath step per state, start only sampled in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SQ;
      SQ:      state_next = MA;
      MA:      state_next = MB;
      MB:      state_next = SUM;
      SUM:     state_next = MK;
      MK:      state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bf_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      k_r   <= '0;
      sq_r  <= '0;
      t1_r  <= '0;
      t2_r  <= '0;
      s_r   <= '0;
      p_r   <= '0;
      freq  <= '0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bf_r <= b_field;
          a_r  <= a_coeff;
          b_r  <= b_coeff;
          c_r  <= c_coeff;
          k_r  <= k_coeff;
        end
        SQ:  sq_r <= SQ_W'(sq_full >> FRAC);
        MA:  t2_r <= t2_full;
        MB:  t1_r <= t1_full;
        SUM: s_r  <= c_ext + t1_r + t2_r;
        MK:  p_r  <= P_W'(p_full);
        OUT: begin
          ready <= 1'b1;
`ifdef B2F_SATURATE_EN
          if (p_r[WW-1])             freq <= '0;
          else if (|p_r[WW-2:DW])    freq <= '1;
          else                       freq <= p_r[DW-1:0];
`else
          freq <= p_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_b_to_f_core.sv
// Self-checking bench for b_to_f_core: directed cases from the test plan plus random vectors
// against an arbitrary-precision reference of the polynomial.
module tb_b_to_f_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] b_field, a_coeff, b_coeff, c_coeff;
  logic [7:0]  k_coeff;
  logic        start;
  logic [31:0] freq;
  logic        ready;

  int vectors = 0;
  int errs    = 0;

  localparam logic [31:0] ONE_T = 32'h0200_0000;

  b_to_f_core dut (
    .clk(clk), .reset(reset), .b_field(b_field), .a_coeff(a_coeff),
    .b_coeff(b_coeff), .c_coeff(c_coeff), .k_coeff(k_coeff),
    .start(start), .freq(freq), .ready(ready)
  );

  always #5 clk = ~clk;

  // Reference: exact integer evaluation in 128 bits, floor shifts, then map()
  function automatic logic [31:0] model(input logic [31:0] bf, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c,
                                        input logic [7:0] k);
    logic [63:0]          sq;
    logic signed [127:0]  av, bv, cv, bfv, sqv, kv, poly, p;
    sq   = ({32'd0, bf} * {32'd0, bf}) >> 25;
    av   = {{96{a[31]}}, a};
    bv   = {{96{b[31]}}, b};
    cv   = {{96{c[31]}}, c};
    bfv  = {96'd0, bf};
    sqv  = {64'd0, sq};
    kv   = {120'd0, k};
    poly = cv + ((bv * bfv) >>> 25) + ((av * sqv) >>> 25);
    p    = poly * kv;
`ifdef B2F_SATURATE_EN
    if (p < 0)                          return 32'h0000_0000;
    else if (p > 128'sd4294967295)      return 32'hFFFF_FFFF;
    else                                return p[31:0];
`else
    return p[31:0];
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One computation: capture, scramble inputs, expect ready after 6 edges with exp
  task automatic run(input string tag, input logic [31:0] bf, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c, input logic [7:0] k,
                     input logic [31:0] exp);
    logic [31:0] prev;
    int          lat;
    logic        moved;
    @(negedge clk);
    b_field = bf; a_coeff = a; b_coeff = b; c_coeff = c; k_coeff = k; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    prev    = freq;
    b_field = $urandom; a_coeff = $urandom; b_coeff = $urandom;
    c_coeff = $urandom; k_coeff = 8'($urandom);
    lat   = 0;
    moved = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ready) begin lat = i; break; end
      if (freq !== prev) moved = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'd6);
    check({tag, "_hold"}, {31'd0, moved}, 32'd0);
    check({tag, "_freq"}, freq, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int   pulses;
    int   first_at, second_at;
    logic seen;
    logic [31:0] bf, a, b, c;
    logic [7:0]  k;

    reset = 1'b1; start = 1'b0;
    b_field = '0; a_coeff = '0; b_coeff = '0; c_coeff = '0; k_coeff = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_freq", freq, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    @(negedge clk) reset = 1'b0;

    run("small", 32'h0000_00FF, 32'd1, 32'd2, 32'd3, 8'd1, 32'd3);
    run("poly_k1", ONE_T, 32'd1, 32'd2, 32'd3, 8'd1, 32'd6);
    run("poly_k4", ONE_T, 32'd1, 32'd2, 32'd3, 8'd4, 32'd24);

    // start held high: results at +6 and +13, nothing in between
    @(negedge clk);
    b_field = ONE_T; a_coeff = 32'd1; b_coeff = 32'd2; c_coeff = 32'd3; k_coeff = 8'd4;
    start = 1'b1;
    @(posedge clk); #1;
    pulses = 0; first_at = 0; second_at = 0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(posedge clk); #1;
      if (ready) begin
        pulses++;
        if (pulses == 1) first_at = cyc; else second_at = cyc;
        check("b2b_freq", freq, 32'd24);
      end
    end
    @(negedge clk) start = 1'b0;
    check("b2b_count", 32'(pulses), 32'd2);
    check("b2b_first", 32'(first_at), 32'd6);
    check("b2b_second", 32'(second_at), 32'd13);
    seen = 1'b0;
    repeat (9) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("b2b_stop", {31'd0, seen}, 32'd0);

`ifdef B2F_SATURATE_EN
    run("overflow", ONE_T, 32'd0, 32'd0, 32'h7FFF_FFFF, 8'd4, 32'hFFFF_FFFF);
    run("negative", ONE_T, 32'd0, 32'd0, 32'hFFFF_FFF6, 8'd1, 32'h0000_0000);
`else
    run("overflow", ONE_T, 32'd0, 32'd0, 32'h7FFF_FFFF, 8'd4, 32'hFFFF_FFFC);
    run("negative", ONE_T, 32'd0, 32'd0, 32'hFFFF_FFF6, 8'd1, 32'hFFFF_FFF6);
`endif
    run("floor", 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd5, 8'd1, 32'd4);
    run("poly_k1b", ONE_T, 32'd1, 32'd2, 32'd3, 8'd1, 32'd6);

    // Reset three cycles into a computation: aborted, freq cleared
    @(negedge clk);
    b_field = ONE_T; a_coeff = 32'd1; b_coeff = 32'd2; c_coeff = 32'd3; k_coeff = 8'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    check("abort_freq", freq, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (ready) seen = 1'b1; end
    check("abort_nopulse", {31'd0, seen}, 32'd0);
    check("abort_freq_after", freq, 32'd0);

    run("recover", ONE_T, 32'd1, 32'd2, 32'd3, 8'd4, 32'd24);
    run("k_zero", ONE_T, 32'd1, 32'd2, 32'd3, 8'd0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      bf = $urandom; a = $urandom; b = $urandom; c = $urandom; k = 8'($urandom);
      if (n % 4 == 0) begin
        a = 32'($signed(32'($urandom_range(0, 2000))) - 1000);
        bf = 32'($urandom_range(0, 32'h1000_0000));
      end
      run("random", bf, a, b, c, k, model(bf, a, b, c, k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/b_to_f_core.md
# b_to_f_core

Fixed-point calculator that converts a magnetic-field reading into a DDS frequency tuning word. It evaluates a quadratic field-to-frequency polynomial scaled by the RF harmonic number. It sits between the field-measurement path and the DDS channels, which use `freq` as their phase increment (Freq[Hz]·2^32/F_clk). The design uses one clock domain with a sequential multi-cycle datapath.

## Interface
- No parameters.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-high; returns the block to its default state.
- `b_field`  in  32  — unsigned field, format Q7.25 in tesla (LSB = 2^-25 T ≈ 29.8 nT, max ≈ 128 T).
- `a_coeff`  in  32  — signed quadratic coefficient, in tuning-word LSB per T².
- `b_coeff`  in  32  — signed linear coefficient, in tuning-word LSB per T.
- `c_coeff`  in  32  — signed offset, in tuning-word LSB.
- `k_coeff`  in  8  — unsigned harmonic number.
- `start`  in  1  — level request; sampled only in IDLE.
- `freq`  out  32  — result tuning word; holds its value between results.
- `ready`  out  1  — one-cycle pulse that marks a new `freq`.

## Operation
- Computes poly = c + ((b·B) >>> 25) + ((a·(B²>>25)) >>> 25).
- Computes result = k·poly.
- `>>>` is an arithmetic shift, which floors toward −∞. `B²>>25` is a logical shift of the 64-bit square.
- All intermediates are wide enough to hold the result without loss: the sum and product are at least 72-bit signed.
- State machine:
  - IDLE: if `start`=1, capture all five inputs into internal registers and go to SQ. Otherwise stay in IDLE.
  - SQ: sq = (B·B) >> 25.
  - MA: t2 = (a·sq) >>> 25.
  - MB: t1 = (b·B) >>> 25.
  - SUM: s = c + t1 + t2.
  - MK: p = s·k (k zero-extended).
  - OUT: `freq` ← map(p), `ready` ← 1, next state IDLE.
- `ready` is 0 in every state except the cycle after OUT writes it.
- Input changes after capture are ignored until the next IDLE sample.
- If `start` is held high, the block computes back-to-back results continuously.
- k = 0 produces `freq` = 0.
- map(p) is defined under Configuration.

## Timing
- Reset values: `freq` = 32'h0, `ready` = 0, state IDLE, captured registers 0.
- If reset is asserted mid-computation, the computation is aborted with no `ready` pulse. Computation resumes from IDLE after reset is released.
- Latency: `start` sampled high at edge N produces `ready`=1 and the new `freq` after edge N+6.
- `ready` lasts exactly one cycle.
- `freq` changes only on the edge that raises `ready`.
- Throughput with `start` held high: one result every 7 cycles. The next capture happens at edge N+7, which is the IDLE cycle that follows OUT.
- If `start` is deasserted during a computation, the computation still completes.

## Configuration
- Macro: `B2F_SATURATE_EN`.
- When defined, map(p) clamps the result:
  - p < 0 → 32'h0000_0000.
  - p > 2^32−1 → 32'hFFFF_FFFF.
  - Otherwise p[31:0].
- When undefined, map(p) = p[31:0], i.e. wrap modulo 2^32 with no clamping.

## Test plan
- Reset default and small field: reset → `freq`=0 and `ready`=0. Release reset, then apply B=32'hFF, a=1, b=2, c=3, k=1, start=1. Required: `ready` pulses 6 cycles after sampling and `freq`=3.
- 1 T polynomial: B=32'h0200_0000, a=1, b=2, c=3. With k=1 → `freq`=6. With k=4 → `freq`=24. `ready` pulses once per computation, every 7 cycles while `start` is held.
- Overflow: a=b=0, c=32'h7FFF_FFFF, k=4. With `B2F_SATURATE_EN` → 32'hFFFF_FFFF. Without → 32'hFFFF_FFFC.
- Negative result: a=b=0, c=32'hFFFF_FFF6 (−10), k=1. With `B2F_SATURATE_EN` → 0. Without → 32'hFFFF_FFF6.
- Floor rounding: B=1, b=32'hFFFF_FFFF (−1), a=0, c=5, k=1. Required: `freq`=4.
- Reset and input isolation:
  - Assert reset 3 cycles after start → no `ready` pulse, `freq`=0.
  - Change b_field during a run → the result reflects only the captured value.
  - k=0 → `freq`=0.
